// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the round-robin shared capture register.
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam arb_state_t STATE_RST   = IDLE;
    localparam logic       Q_VALID_RST = 1'b0;

    // An index field is never narrower than one bit, even for a single slot.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_rr_arbiter_if.sv
// Requester bus plus shared-register outputs of the round-robin capture arbiter.
interface dff_rr_arbiter_if
    import dff_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 1
);
    localparam int SW = clog2_min1(NREQ);

    // Requester i transfers on a rising edge where req_valid[i] & req_ready[i];
    // it holds req_valid[i] and its word stable until then, and req_ready is
    // one-hot (or zero) and never depends on req_data.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      q;
    logic               q_valid;
    logic [SW-1:0]      q_src;
    logic               busy;
    arb_state_t         dbg_state;
    logic [SW-1:0]      dbg_ptr;

    modport master (
        output req_valid, req_data,
        input  req_ready, q, q_valid, q_src, busy, dbg_state, dbg_ptr
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, q, q_valid, q_src, busy, dbg_state, dbg_ptr
    );

endinterface

// File: rtl/dff_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after base, wrapping.
module dff_rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   base,
    output logic [NREQ-1:0] gnt,
    output logic [SW-1:0]   gnt_idx,
    output logic            any
);

    localparam int IW = SW + 1;

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // base is always below NREQ, so one subtraction is enough to wrap.
            idx = {1'b0, base} + IW'(k);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (!any && req[idx[SW-1:0]]) begin
                gnt[idx[SW-1:0]] = 1'b1;
                gnt_idx          = idx[SW-1:0];
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter feeding one shared capture register, with a hold window
// of HOLD busy cycles after every capture.
module dff_rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int            NREQ    = 4,
    parameter int            DW      = 1,
    parameter int            HOLD    = 2,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    dff_rr_arbiter_if.slave bus
);

    localparam int            SW       = clog2_min1(NREQ);
    localparam int            CW       = clog2_min1(HOLD + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD > 0 ? HOLD - 1 : 0);
    localparam logic [SW-1:0] LAST_IDX = SW'(NREQ - 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic [SW-1:0] q_src_q, q_src_d;

    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            grant_en;
    logic            xfer;
    logic [DW-1:0]   sel_data;

    dff_rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req     (bus.req_valid),
        .base    (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // rst gates the grant directly so nothing is offered while reset is held.
    assign grant_en = (state_q == IDLE) && !rst;
    assign xfer     = grant_en && gnt_any;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_data = bus.req_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_src_d   = q_src_q;
        q_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    q_d       = sel_data;
                    q_src_d   = gnt_idx;
                    q_valid_d = 1'b1;
                    ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    if (HOLD > 0) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STATE_RST;
            ptr_q     <= '0;
            cnt_q     <= '0;
            q_q       <= RST_VAL;
            q_valid_q <= Q_VALID_RST;
            q_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_src_q   <= q_src_d;
        end
    end

    assign bus.req_ready = grant_en ? gnt : '0;
    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.q_src     = q_src_q;
    assign bus.busy      = (state_q == BUSY);
    assign bus.dbg_state = state_q;
    assign bus.dbg_ptr   = ptr_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
        (bus.req_ready & ~bus.req_valid) == '0);
    a_no_grant_busy: assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY) |-> (bus.req_ready == '0));

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Bench for dff_rr_arbiter: directed scenarios plus a randomized run against a
// cycle-level round-robin reference model; a HOLD=0 instance covers streaming.
module tb_dff_rr_arbiter;
  import dff_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int HOLD = 2;
  localparam logic [7:0] RST_Q = 8'h3C;

  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;

  // reference model state for the HOLD=2 instance
  int m_ptr;
  int m_hold;
  logic [7:0] m_q;
  logic [1:0] m_src;
  logic m_qv;

  logic [7:0] exp_q[$];
  logic [1:0] exp_src_q[$];

  always #5 clk = ~clk;

  dff_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus2 ();
  dff_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus0 ();

  dff_rr_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(HOLD), .RST_VAL(RST_Q)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  dff_rr_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(0), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_ready(input logic [3:0] v);
    if (m_hold > 0) return 4'b0000;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (v[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_hold = 0;
    m_q = RST_Q;
    m_src = 2'd0;
    m_qv = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] v, input logic [31:0] d);
    logic [3:0] r;
    r = model_ready(v);
    if (m_hold > 0) begin
      m_hold--;
      m_qv = 1'b0;
    end else if (r != 4'b0000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) begin
          m_q = d[i*8 +: 8];
          m_src = 2'(i);
          m_ptr = (i + 1) % NREQ;
        end
      end
      m_qv = 1'b1;
      m_hold = HOLD;
    end else begin
      m_qv = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus2.req_valid = '0;
    bus2.req_data = '0;
    bus0.req_valid = '0;
    bus0.req_data = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // sample ready before the edge, clock once, advance the model, settle
  task automatic step(output logic [3:0] rdy_seen, output logic [3:0] rdy_exp);
    #1;
    rdy_seen = bus2.req_ready;
    rdy_exp = model_ready(bus2.req_valid);
    @(posedge clk);
    model_edge(bus2.req_valid, bus2.req_data);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [3:0] rs, re;
    @(negedge clk);
    rst = 1'b1;
    bus2.req_valid = 4'b1111;
    bus2.req_data = 32'h13121110;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      n_vec++;
      if ({bus2.req_ready, bus2.q, bus2.q_valid, bus2.q_src, bus2.busy} !==
          {4'b0000, RST_Q, 1'b0, 2'd0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold k=%0d: got rdy=%b q=%h qv=%b src=%0d busy=%b want rdy=0000 q=%h qv=0 src=0 busy=0",
                 k, bus2.req_ready, bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, RST_Q);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(rs, re);
    n_vec++;
    if (rs !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_ready: got %b want 0001", rs);
    end
    n_vec++;
    if ({bus2.q, bus2.q_valid, bus2.q_src} !== {8'h10, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL reset_first_capture: got q=%h qv=%b src=%0d want q=10 qv=1 src=0",
               bus2.q, bus2.q_valid, bus2.q_src);
    end
  endtask

  task automatic test_single();
    logic [3:0] rs, re;
    do_reset();
    bus2.req_valid = 4'b0100;
    bus2.req_data = {8'h5F, 8'hA5, 8'h3E, 8'h71};
    step(rs, re);
    n_vec++;
    if (rs !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100", rs);
    end
    n_vec++;
    if ({bus2.q, bus2.q_valid, bus2.q_src, bus2.busy} !== {8'hA5, 1'b1, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL single_capture: got q=%h qv=%b src=%0d busy=%b want q=a5 qv=1 src=2 busy=1",
               bus2.q, bus2.q_valid, bus2.q_src, bus2.busy);
    end
    bus2.req_data[23:16] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      step(rs, re);
      n_vec++;
      if (rs !== re) begin
        n_err++;
        $display("FAIL single_ready_k%0d: got %b want %b", k, rs, re);
      end
      n_vec++;
      if ({bus2.q, bus2.q_valid, bus2.q_src, bus2.busy} !== {m_q, m_qv, m_src, m_hold > 0}) begin
        n_err++;
        $display("FAIL single_out_k%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", k,
                 bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, m_q, m_qv, m_src, m_hold > 0);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] rs, re;
    logic [7:0] ed;
    logic [1:0] es;
    int last_cap;
    do_reset();
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_src_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    last_cap = -1;
    bus2.req_valid = 4'b1111;
    bus2.req_data = 32'h13121110;
    for (int cyc = 0; cyc < 15; cyc++) begin
      step(rs, re);
      n_vec++;
      if (rs !== re) begin
        n_err++;
        $display("FAIL contention_ready_c%0d: got %b want %b", cyc, rs, re);
      end
      n_vec++;
      if ({bus2.q, bus2.q_valid, bus2.q_src, bus2.busy} !== {m_q, m_qv, m_src, m_hold > 0}) begin
        n_err++;
        $display("FAIL contention_out_c%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", cyc,
                 bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, m_q, m_qv, m_src, m_hold > 0);
      end
      if (bus2.q_valid === 1'b1 && exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        es = exp_src_q.pop_front();
        n_vec++;
        if ({bus2.q, bus2.q_src} !== {ed, es}) begin
          n_err++;
          $display("FAIL contention_seq_c%0d: got q=%h src=%0d want q=%h src=%0d",
                   cyc, bus2.q, bus2.q_src, ed, es);
        end
        if (last_cap >= 0) begin
          n_vec++;
          if (cyc - last_cap != HOLD + 1) begin
            n_err++;
            $display("FAIL contention_gap_c%0d: got %0d want %0d", cyc, cyc - last_cap, HOLD + 1);
          end
        end
        last_cap = cyc;
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL contention_count: got %0d captures left want 0", exp_q.size());
    end
  endtask

  task automatic test_hold0();
    logic [1:0] e;
    do_reset();
    bus0.req_valid = 4'b1011;
    bus0.req_data = 32'h23222120;
    exp_src_q = {2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      e = exp_src_q.pop_front();
      #1;
      n_vec++;
      if (bus0.req_ready !== (4'b0001 << e)) begin
        n_err++;
        $display("FAIL hold0_ready_k%0d: got %b want grant %0d", k, bus0.req_ready, e);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus0.q, bus0.q_valid, bus0.q_src, bus0.busy} !== {8'h20 + 8'(e), 1'b1, e, 1'b0}) begin
        n_err++;
        $display("FAIL hold0_out_k%0d: got q=%h qv=%b src=%0d busy=%b want q=%h qv=1 src=%0d busy=0",
                 k, bus0.q, bus0.q_valid, bus0.q_src, bus0.busy, 8'h20 + 8'(e), e);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [3:0] rs, re;
    do_reset();
    bus2.req_valid = 4'b0100;
    bus2.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    step(rs, re);
    n_vec++;
    if ({bus2.q, bus2.q_valid, bus2.q_src} !== {8'h77, 1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL midbusy_capture: got q=%h qv=%b src=%0d want q=77 qv=1 src=2",
               bus2.q, bus2.q_valid, bus2.q_src);
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (bus2.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midbusy_pre: got busy=%b want 1", bus2.busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus2.busy, bus2.q_valid, bus2.q, bus2.q_src, bus2.req_ready} !==
        {1'b0, 1'b0, RST_Q, 2'd0, 4'b0000}) begin
      n_err++;
      $display("FAIL midbusy_async: got busy=%b qv=%b q=%h src=%0d rdy=%b want busy=0 qv=0 q=%h src=0 rdy=0000",
               bus2.busy, bus2.q_valid, bus2.q, bus2.q_src, bus2.req_ready, RST_Q);
    end
    bus2.req_valid = 4'b1100;
    bus2.req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(rs, re);
    n_vec++;
    if (rs !== 4'b0100) begin
      n_err++;
      $display("FAIL midbusy_first_ready: got %b want 0100", rs);
    end
    n_vec++;
    if ({bus2.q, bus2.q_valid, bus2.q_src} !== {8'h22, 1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL midbusy_first_capture: got q=%h qv=%b src=%0d want q=22 qv=1 src=2",
               bus2.q, bus2.q_valid, bus2.q_src);
    end
  endtask

  task automatic test_withdrawn();
    logic [3:0] rs, re;
    logic [3:0] vseq[7];
    int src1_caps;
    do_reset();
    vseq = '{4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b1111, 4'b1111, 4'b1111};
    bus2.req_data = {8'h99, 8'h44, 8'hEE, 8'h01};
    src1_caps = 0;
    for (int k = 0; k < 7; k++) begin
      bus2.req_valid = vseq[k];
      step(rs, re);
      n_vec++;
      if (rs !== re) begin
        n_err++;
        $display("FAIL withdrawn_ready_k%0d: got %b want %b", k, rs, re);
      end
      n_vec++;
      if ({bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, bus2.dbg_ptr} !==
          {m_q, m_qv, m_src, m_hold > 0, 2'(m_ptr)}) begin
        n_err++;
        $display("FAIL withdrawn_out_k%0d: got %h/%b/%0d/%b/p%0d want %h/%b/%0d/%b/p%0d", k,
                 bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, bus2.dbg_ptr,
                 m_q, m_qv, m_src, m_hold > 0, m_ptr);
      end
      if (bus2.q_valid === 1'b1 && bus2.q_src === 2'd1) src1_caps++;
      if (k == 3) begin
        n_vec++;
        if ({bus2.q, bus2.q_src, bus2.dbg_ptr} !== {8'h99, 2'd3, 2'd0}) begin
          n_err++;
          $display("FAIL withdrawn_wrap: got q=%h src=%0d ptr=%0d want q=99 src=3 ptr=0",
                   bus2.q, bus2.q_src, bus2.dbg_ptr);
        end
      end
    end
    n_vec++;
    if (src1_caps != 0) begin
      n_err++;
      $display("FAIL withdrawn_skip: got %0d captures from requester 1 want 0", src1_caps);
    end
  endtask

  task automatic test_random();
    logic [3:0] rs, re;
    logic [3:0] v;
    int others[NREQ];
    do_reset();
    v = 4'b0000;
    for (int i = 0; i < NREQ; i++) others[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          bus2.req_data[i*8 +: 8] = 8'($urandom);
          others[i] = 0;
        end else if (v[i] && $urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
      end
      bus2.req_valid = v;
      step(rs, re);
      n_vec++;
      if (rs !== re) begin
        n_err++;
        $display("FAIL random_ready_c%0d: got %b want %b", cyc, rs, re);
      end
      n_vec++;
      if ({bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, bus2.dbg_ptr, bus2.dbg_state == BUSY} !==
          {m_q, m_qv, m_src, m_hold > 0, 2'(m_ptr), m_hold > 0}) begin
        n_err++;
        $display("FAIL random_out_c%0d: got %h/%b/%0d/%b/p%0d want %h/%b/%0d/%b/p%0d", cyc,
                 bus2.q, bus2.q_valid, bus2.q_src, bus2.busy, bus2.dbg_ptr,
                 m_q, m_qv, m_src, m_hold > 0, m_ptr);
      end
      // a waiting requester may be passed over by at most NREQ-1 others
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && bus2.q_valid === 1'b1 && bus2.q_src !== 2'(i)) begin
          others[i]++;
          n_vec++;
          if (others[i] > NREQ - 1) begin
            n_err++;
            $display("FAIL random_fair_c%0d: requester %0d passed over %0d times want <= %0d",
                     cyc, i, others[i], NREQ - 1);
          end
        end
      end
      if (m_qv) v[m_src] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus2.req_valid = '0;
    bus2.req_data = '0;
    bus0.req_valid = '0;
    bus0.req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_contention();
    test_hold0();
    test_reset_mid_busy();
    test_withdrawn();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dff_rr_arbiter.md
# dff_rr_arbiter

Round-robin arbiter that shares one `dff`-style capture register between `NREQ` requesters. Each requester offers a `DW`-bit word with a valid/ready handshake. The block grants one requester per transfer, captures that requester's word into the shared register and reports the source. After each capture it holds the register busy for a programmable number of cycles. It sits between the stimulus requesters in `tb_top` and the shared sampling stage, and replaces direct wiring of `d`.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `DW`, 1, data width per requester (matches `A`)
- `HOLD`, 2, busy cycles after each capture (≥0)
- `RST_VAL`, 0, reset value of `q`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  requester i offers a word
- `req_data`  in  NREQ*DW  requester i word at `[i*DW +: DW]`
- `req_ready`  out  NREQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `q`  out  DW  shared register contents
- `q_valid`  out  1  one-cycle pulse: `q` updated this cycle
- `q_src`  out  SW=max(1,$clog2(NREQ))  index of last captured requester
- `busy`  out  1  register in hold window, no grants

## Operation
- FSM states: IDLE, BUSY. Pointer `ptr` (SW bits) holds the highest-priority requester index.
- IDLE: `g` is the first `i` with `req_valid[i]=1`, scanning `ptr, ptr+1, …` modulo NREQ. `req_ready` is combinationally one-hot at `g` and all-zero when no valid is present. At most one bit is set.
- Capture at edge T when a transfer occurs:
  - `q<=req_data[g]`, `q_src<=g`, `q_valid<=1`
  - `ptr<=(g+1) mod NREQ`, with wrap-around at NREQ-1 → 0
  - HOLD>0: go to BUSY with `cnt<=HOLD-1`. HOLD=0: stay in IDLE.
- No transfer: `q_valid<=0`; `q`, `q_src` and `ptr` unchanged.
- BUSY: `req_ready=0`, `busy=1`. If `cnt==0`, go to IDLE; otherwise decrement `cnt`. No captures occur in BUSY.
- Requesters hold `valid`/`data` stable until granted. A requester that deasserts `valid` before grant is skipped with no side effects.
- Fairness: a continuously valid requester is granted within (NREQ-1)*(HOLD+1)+1 cycles.
- `rst` high, asynchronous, with effect independent of `clk`:
  - state=IDLE, `ptr=0`, `cnt=0`
  - `q=RST_VAL`, `q_valid=0`, `q_src=0`, `busy=0`
  - `req_ready` forced to 0 while `rst` is high
  - Reset mid-BUSY aborts the hold window immediately.

## Timing
- Grant-to-output latency is 1 cycle. A transfer at edge T gives `q`, `q_src` and `q_valid=1` during T..T+1.
- `busy=1` for exactly HOLD cycles after the capture edge. The next grant is possible at edge T+HOLD+1.
- With HOLD=0, back-to-back grants every cycle are allowed and `q_valid` may stay high continuously.
- `req_ready` depends combinationally on `req_valid`, state and `ptr` only, never on `req_data`.
- The first grant is possible on the first rising edge after `rst` deasserts.

## Structure
- Package `dff_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY}
  - function `clog2_min1`
  - reset-value constants
- Sub-module `dff_rr_pick`: combinational rotating priority encoder.
  - Inputs: `req` (NREQ), `base` (SW).
  - Outputs: one-hot `gnt` and index `gnt_idx`, plus `any`.
- Top: FSM, hold counter, pointer and capture register. The capture register is `dff`-equivalent, widened to DW.

## Test plan
- Reset (NREQ=4, DW=8, HOLD=2, RST_VAL=0x3C): assert `rst` with all `req_valid=1111` → `q=0x3C`, `q_valid=0`, `q_src=0`, `busy=0`, `req_ready=0000` throughout. First grant after release goes to requester 0.
- Single request: `req_valid=0100`, data2=0xA5 at T → `req_ready=0100` at T. `q=0xA5`, `q_src=2`, `q_valid=1` at T+1. `busy=1` for 2 cycles. Next accept no earlier than T+3.
- Full contention, HOLD=2: `req_valid=1111` held, data_i=0x10+i → captures 0x10, 0x11, 0x12, 0x13, 0x10 with `q_src` 0, 1, 2, 3, 0, spaced 3 cycles apart.
- HOLD=0 build: `req_valid=1011` held → grants 0, 1, 3, 0, 1 on consecutive cycles. `q_valid` stays high and `busy` never asserts.
- Reset mid-BUSY: assert `rst` one cycle after a capture from requester 2 → `busy`, `q_valid` and `q` clear immediately. After release with `req_valid=1100`, requester 2 is granted first because `ptr` reset to 0.
- Withdrawn request: `req_valid=0010` drops during BUSY before grant, then `req_valid=1000` → only requester 3 is captured, and `ptr` becomes 0 by wrap-around.
